// File: rtl/imem_loader_pkg.sv
// Shared state encoding and byte-framing constants for the instruction-memory stream loader.
// CKSUM is only reachable when IMEM_LOADER_CKSUM_EN is defined.
package imem_loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        CKSUM = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/imem_stream_loader_byte_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid pulses the cycle
// after the fourth byte of a word is accepted.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] asm_q, asm_d;
    logic        word_valid_q, word_valid_d;
    logic [31:0] word_q, word_d;

    // Earlier bytes shift down so byte 0 ends up in bits [7:0] of the word.
    always_comb begin
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        if (clear) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (byte_valid) begin
            if (cnt_q == 2'(WORD_BYTES - 1)) begin
                word_d       = {byte_data, asm_q};
                word_valid_d = 1'b1;
                cnt_d        = '0;
            end else begin
                asm_d = {byte_data, asm_q[23:8]};
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

    assign last_byte  = (cnt_q == 2'(WORD_BYTES - 1));
    assign word_valid = word_valid_q;
    assign word_data  = word_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the CPU in reset until done.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int BASE_WADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t POST_DATA = CKSUM;
`else
    localparam state_t POST_DATA = DONE;
`endif

    state_t            state_q, state_d;
    logic [7:0]        n_lo_q, n_lo_d;
    logic [15:0]       words_left_q, words_left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    logic        xfer;
    logic        start_ok;
    logic        last_byte;
    logic        word_valid;
    logic [31:0] word_data;
    logic [15:0] hdr_n;

    assign xfer     = in_valid & in_ready_q;
    assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign hdr_n    = {in_data, n_lo_q};

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (xfer && (state_q == DATA)),
        .byte_data  (in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        state_d      = state_q;
        n_lo_d       = n_lo_q;
        words_left_d = words_left_q;
        addr_d       = addr_q;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_d      = cksum_q;
`endif
        if (start_ok) begin
            state_d = HDR0;
            addr_d  = ADDR_W'(BASE_WADDR);
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_d = '0;
`endif
        end else begin
            if (word_valid) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            case (state_q)
                HDR0: if (xfer) begin
                    n_lo_d  = in_data;
                    state_d = HDR1;
                end
                HDR1: if (xfer) begin
                    words_left_d = hdr_n;
                    if ({1'b0, hdr_n} > DEPTH_W) begin
                        state_d = ERR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = POST_DATA;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    cksum_d = cksum_q ^ in_data;
`endif
                    if (last_byte) begin
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q == 16'd1) begin
                            state_d = POST_DATA;
                        end
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                CKSUM: if (xfer) begin
                    state_d = (in_data == cksum_q) ? DONE : ERR;
                end
`endif
                default: ;
            endcase
        end

        // done/err lag DONE/ERR entry by a cycle so the final write strobe never overlaps done.
        in_ready_d = state_d inside {HDR0, HDR1, DATA, CKSUM};
        busy_d     = in_ready_d;
        done_d     = (state_q == DONE) && (state_d == DONE);
        err_d      = (state_q == ERR) && (state_d == ERR);
        cpu_rst_d  = !done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            n_lo_q       <= '0;
            words_left_q <= '0;
            addr_q       <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_rst_q    <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_lo_q       <= n_lo_d;
            words_left_q <= words_left_d;
            addr_q       <= addr_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cpu_rst_q    <= cpu_rst_d;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_data;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed self-checking bench for imem_stream_loader; also covers the trailer byte
// when IMEM_LOADER_CKSUM_EN is defined.
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stalls;

    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_cyc_q  [$];
    int          done_cyc;
    logic        cpu_rst_at_done;
    int          overlap;
    logic        done_prev = 1'b0;

    imem_stream_loader #(
        .ADDR_W     (8),
        .DEPTH      (256),
        .BASE_WADDR (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log and done-edge capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            wr_cyc_q.push_back(cyc);
            if (done || !cpu_rst) overlap++;
        end
        if (done && !done_prev) begin
            done_cyc        = cyc;
            cpu_rst_at_done = cpu_rst;
        end
        done_prev = done;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc        = -1;
        cpu_rst_at_done = 1'bx;
        overlap         = 0;
        stalls          = 0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
        stalls += n;
        checkOutput("byte_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sendTest1(input bit gappy);
        logic [7:0] s [10];
        int         g [10];
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        g = '{0, 2, 1, 3, 0, 5, 1, 0, 2, 4};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(s[i], gappy ? g[i] : 0);
            if (gappy && i == 4) pulseStart();
        end
    endtask

    task automatic waitEnd(input string tag);
        int n = 0;
        while (!(done || err) && n < 30) begin @(posedge clk); #1; n++; end
        checkOutput(tag, {31'd0, done | err}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic verifyTest1(input string p);
        checkOutput({p, "_nwr"}, wr_data_q.size(), 32'd2);
        if (wr_data_q.size() == 2) begin
            checkOutput({p, "_addr0"}, {24'd0, wr_addr_q[0]}, 32'd0);
            checkOutput({p, "_data0"}, wr_data_q[0], 32'h0050_0013);
            checkOutput({p, "_addr1"}, {24'd0, wr_addr_q[1]}, 32'd1);
            checkOutput({p, "_data1"}, wr_data_q[1], 32'h00A0_0093);
            checkOutput({p, "_done_lat"}, done_cyc, wr_cyc_q[1] + 1);
        end
        checkOutput({p, "_cpurst_at_done"}, {31'd0, cpu_rst_at_done}, 32'd0);
        checkOutput({p, "_we_overlap"}, overlap, 32'd0);
        checkOutput({p, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({p, "_err"}, {31'd0, err}, 32'd0);
        checkOutput({p, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd0);
        checkOutput({p, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({p, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic checkResetValues(input string p);
        checkOutput({p, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        checkOutput({p, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        checkOutput({p, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
        checkOutput({p, "_imem_wdata"}, imem_wdata, 32'd0);
        checkOutput({p, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
        checkOutput({p, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({p, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({p, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clearLog();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetValues("rst");

        // Two words, continuous valid.
        clearLog();
        pulseStart();
        sendTest1(1'b0);
`ifdef IMEM_LOADER_CKSUM_EN
        applyStimulus(8'h70, 0);
`endif
        waitEnd("t1_end");
        verifyTest1("t1");
        checkOutput("t1_stalls", stalls, 32'd0);

        // Same stream with idle gaps and an ignored start mid-load.
        clearLog();
        pulseStart();
        checkOutput("t2_done_cleared", {31'd0, done}, 32'd0);
        checkOutput("t2_cpu_rst_reasserted", {31'd0, cpu_rst}, 32'd1);
        sendTest1(1'b1);
`ifdef IMEM_LOADER_CKSUM_EN
        applyStimulus(8'h70, 1);
`endif
        waitEnd("t2_end");
        verifyTest1("t2");
        checkOutput("t2_stalls", stalls, 32'd0);

        // Empty image.
        clearLog();
        pulseStart();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
`ifdef IMEM_LOADER_CKSUM_EN
        applyStimulus(8'h00, 0);
`endif
        waitEnd("t3_end");
        checkOutput("t3_nwr", wr_data_q.size(), 32'd0);
        checkOutput("t3_done", {31'd0, done}, 32'd1);
        checkOutput("t3_err", {31'd0, err}, 32'd0);
        checkOutput("t3_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        // Oversized image (257 words), then recovery with a good stream.
        clearLog();
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t4_err", {31'd0, err}, 32'd1);
        checkOutput("t4_done", {31'd0, done}, 32'd0);
        checkOutput("t4_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("t4_busy", {31'd0, busy}, 32'd0);
        checkOutput("t4_nwr", wr_data_q.size(), 32'd0);
        clearLog();
        pulseStart();
        checkOutput("t4_err_cleared", {31'd0, err}, 32'd0);
        sendTest1(1'b0);
`ifdef IMEM_LOADER_CKSUM_EN
        applyStimulus(8'h70, 0);
`endif
        waitEnd("t4r_end");
        verifyTest1("t4r");

`ifdef IMEM_LOADER_CKSUM_EN
        // Trailer: 0x13^0x50^0x93^0xA0 = 0x70 matches, 0x71 does not.
        clearLog();
        pulseStart();
        sendTest1(1'b0);
        applyStimulus(8'h70, 0);
        waitEnd("t6a_end");
        checkOutput("t6a_done", {31'd0, done}, 32'd1);
        checkOutput("t6a_err", {31'd0, err}, 32'd0);
        clearLog();
        pulseStart();
        sendTest1(1'b0);
        applyStimulus(8'h71, 0);
        waitEnd("t6b_end");
        checkOutput("t6b_err", {31'd0, err}, 32'd1);
        checkOutput("t6b_done", {31'd0, done}, 32'd0);
        checkOutput("t6b_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        checkOutput("t6b_nwr", wr_data_q.size(), 32'd2);
`endif

        // Reset after six data bytes: only word 0 may be written.
        clearLog();
        pulseStart();
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h13, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h50, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h93, 0);
        applyStimulus(8'h00, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkResetValues("t5");
        repeat (5) begin @(posedge clk); #1; end
        checkOutput("t5_nwr", wr_data_q.size(), 32'd1);
        if (wr_data_q.size() == 1) begin
            checkOutput("t5_data0", wr_data_q[0], 32'h0050_0013);
        end
        checkOutput("t5_busy_after", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
